// File: rtl/mux_channel_scanner.sv
// -----------------------------------------------------------------------------
// mux_channel_scanner
//
// Registered N_CH-to-1 channel multiplexer with two operating modes:
//   - manual : the channel picked by sel_in appears on out one cycle later.
//   - scan   : a start pulse launches a sequencer that walks channels
//              0..N_CH-1, holding each for DWELL cycles while re-sampling the
//              live input data of the current channel every cycle.
//
// Build option:
//   MUX_SCAN_WRAP_EN  when defined the scan wraps from the last channel back
//                     to channel 0 and runs until aborted (mode=0) or reset;
//                     done never pulses. When undefined a single pass is made
//                     and done pulses for one cycle at the end.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         packed channels, channel c = in[c*DATA_W +: DATA_W]
//   sel_in     manual channel select
//   mode       0 = manual, 1 = scan
//   start      scan launch pulse (honoured only in IDLE with mode=1)
//   out        registered data of the selected channel
//   out_sel    channel index that out currently reflects
//   out_valid  out/out_sel carry a valid sample this cycle
//   busy       scan in progress
//   done       one-cycle pulse at scan completion
//   dbg_state  current FSM state (IDLE=0, SCAN=1, DONE=2)
//
// Handshake: there is no back-pressure. out_valid qualifies out/out_sel in the
// cycle it is high; a consumer must take the sample that cycle.
// -----------------------------------------------------------------------------
module mux_channel_scanner #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 1,
  parameter int DWELL  = 4,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     mode,
  input  logic                     start,
  output logic [DATA_W-1:0]        out,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [DATA_W-1:0]   out_d;
  logic [SEL_W-1:0]    out_sel_d;
  logic                valid_d;
  logic                busy_d;
  logic                done_d;

  assign dbg_state = state_q;

  // All state and the output stage live in one register bank. The output
  // registers are a function of the state the FSM is in, so the first scan
  // sample appears one edge after the start edge and the done pulse appears
  // one edge after the last dwell cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      dwell_q   <= '0;
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dwell_q   <= dwell_d;
      out       <= out_d;
      out_sel   <= out_sel_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dwell_d   = dwell_q;
    out_d     = out;
    out_sel_d = out_sel;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mode) begin
          // Selects beyond the last channel (non power-of-two N_CH) are
          // never used as an index; they produce a zero, invalid sample.
          if (int'(sel_in) < N_CH) begin
            out_d     = in[int'(sel_in)*DATA_W +: DATA_W];
            out_sel_d = sel_in;
            valid_d   = 1'b1;
          end else begin
            out_d = '0;
          end
        end else if (start) begin
          state_d = S_SCAN;
          ch_d    = '0;
          dwell_d = '0;
        end
      end

      S_SCAN: begin
        if (!mode) begin
          // Abort: drop back to IDLE with cleared counters, no done pulse.
          state_d = S_IDLE;
          ch_d    = '0;
          dwell_d = '0;
        end else begin
          out_d     = in[int'(ch_q)*DATA_W +: DATA_W];
          out_sel_d = ch_q;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          if (dwell_q == LAST_DW) begin
            dwell_d = '0;
            if (ch_q == LAST_CH) begin
              ch_d = '0;
`ifdef MUX_SCAN_WRAP_EN
              state_d = S_SCAN;
`else
              state_d = S_DONE;
`endif
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
